match_scoreboard: RTL
=====================

// Module: match_scoreboard
// PURPOSE
//   Sequential successor to the combinational match-finish check. Accumulates round
//   results for a two-player match and tracks rounds, P1 wins and P2 wins.
//   Declares the finish and the winner using parametrised win-target and round-limit rules.
//   Sits between the per-round judge and the display/FSM top; keeps the
//   fin/printwinner encoding used by the display path.
// PARAMETERS
//   CNT_W       4  width of rounds/p1_wins/p2_wins counters; must hold MAX_ROUNDS
//   MAX_ROUNDS  9  match ends once this many scored rounds (ties included) are played
//   WIN_TARGET  5  match ends as soon as either player reaches this many wins
//   STREAK_LEN  3  consecutive-win early-finish length (used only with macro below)
// PORTS
//   clk           in   1      single system clock, rising edge
//   rst_n         in   1      asynchronous active-low reset
//   start         in   1      1-cycle pulse: clear counters, begin new match
//   round_valid   in   1      1-cycle pulse: round_result valid this cycle
//   round_result  in   2      00 tie, 01 P1 wins, 10 P2 wins, 11 illegal
//   rounds        out  CNT_W  scored rounds so far
//   p1_wins       out  CNT_W  P1 round wins
//   p2_wins       out  CNT_W  P2 round wins
//   busy          out  1      1 while state = PLAY
//   fin           out  1      1 while state = DONE
//   printwinner   out  2      00 none, 10 P1, 11 P2, 01 draw; valid when fin=1
//   done_pulse    out  1      1-cycle pulse on the PLAY->DONE edge
//   illegal_seen  out  1      sticky: an illegal code was received in PLAY; cleared by start
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; every output 0; streak state cleared.
//   - FSM: IDLE --start--> PLAY; PLAY --finish rule--> DONE; DONE --start--> PLAY.
//     start in PLAY restarts the match: counters, streak and illegal_seen are cleared.
//   - All outputs are registered. A round accepted at edge N is reflected in the counters
//     after edge N. If that round decides the match, fin, printwinner and done_pulse
//     also update at edge N, so latency is 1 cycle from the round_valid cycle.
//   - Accept: round_valid=1 and state=PLAY and start=0.
//     The result code sets the increments: 00 -> rounds+1; 01 -> rounds+1, p1_wins+1;
//     10 -> rounds+1, p2_wins+1; 11 -> no counter change, illegal_seen<=1.
//   - round_valid outside PLAY is ignored with no side effects.
//     start and round_valid in the same cycle: start wins and the round is discarded.
//   - Finish rule, evaluated on the post-update counts, in priority order:
//     1) p1_wins==WIN_TARGET -> 10;  2) p2_wins==WIN_TARGET -> 11;
//     3) rounds==MAX_ROUNDS -> the higher win count wins (10/11); if equal, 01.
//     Only one win counter moves per round, so 1) and 2) are mutually exclusive.
//   - Counters never exceed MAX_ROUNDS/WIN_TARGET because accept stops in DONE; no wrap.
//   - DONE holds the counters, fin=1 and printwinner until start or reset.
//   - printwinner=00 whenever fin=0.
//   - rst_n asserted mid-match clears everything immediately; no round is retained.
// CONFIGURATION
//   SCOREBOARD_STREAK_EN defined: tracks the last winner and its consecutive-win run.
//     A tie or illegal code does not break the run; a win by the other player resets it to 1.
//     The run reaching STREAK_LEN finishes the match for that player. This check runs after
//     rule 2 and before rule 3. The same 1-cycle latency and done_pulse apply.
//   Not defined: no streak logic is synthesised; only rules 1-3 apply.
// TESTING  (defaults MAX_ROUNDS=9, WIN_TARGET=5, STREAK_LEN=3)
//   Reset, then idle 5 cycles with round_valid pulses -> all outputs 0, no count change.
//   start; P1,P2,P1,P1,T,P1,P1 -> fin=1, printwinner=10 on the 7th round; p1_wins=5,
//     p2_wins=1, rounds=7; done_pulse high for 1 cycle; later round_valid ignored.
//   start; 4xP1, 4xP2 interleaved, 1xT -> rounds=9, fin=1, printwinner=01.
//   start; 3xP1, 4xP2, 2xT interleaved -> fin at round 9, printwinner=11.
//   start+round_valid(01) in the same cycle -> p1_wins=0. Code 11 in PLAY -> counters
//     unchanged, illegal_seen=1. rst_n=0 mid-match -> outputs 0 without waiting for a clock edge.
//   With SCOREBOARD_STREAK_EN: P2,T,P2,P2 -> fin=1, printwinner=11, rounds=4.
//     Without the macro: same sequence -> fin=0, busy=1.

Source files
------------

// File: rtl/match_scoreboard.sv
// Registered two-player match scoreboard: counts rounds and wins, declares finish and winner.
// Optional SCOREBOARD_STREAK_EN adds a consecutive-win early finish after STREAK_LEN wins.
module match_scoreboard #(
  parameter int CNT_W      = 4,
  parameter int MAX_ROUNDS = 9,
  parameter int WIN_TARGET = 5,
  parameter int STREAK_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             round_valid,
  input  logic [1:0]       round_result,
  output logic [CNT_W-1:0] rounds,
  output logic [CNT_W-1:0] p1_wins,
  output logic [CNT_W-1:0] p2_wins,
  output logic             busy,
  output logic             fin,
  output logic [1:0]       printwinner,
  output logic             done_pulse,
  output logic             illegal_seen
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
  state_t state;

  logic             acc, scored, fin_now;
  logic [1:0]       pw_now;
  logic [CNT_W-1:0] n_rounds, n_p1, n_p2;

`ifdef SCOREBOARD_STREAK_EN
  // last_win holds the winning result code (01/10) of the current run, 00 before any win
  logic [1:0]       last_win, n_last;
  logic [CNT_W-1:0] run, n_run;
`else
  logic [CNT_W-1:0] unused_streak_len;
  assign unused_streak_len = CNT_W'(STREAK_LEN);
`endif

  always_comb begin
    acc      = round_valid && (state == PLAY) && !start;
    scored   = acc && (round_result != 2'b11);
    n_rounds = rounds  + CNT_W'(scored);
    n_p1     = p1_wins + CNT_W'(scored && round_result == 2'b01);
    n_p2     = p2_wins + CNT_W'(scored && round_result == 2'b10);
`ifdef SCOREBOARD_STREAK_EN
    n_last = last_win;
    n_run  = run;
    if (scored && round_result != 2'b00) begin
      n_run  = (round_result == last_win) ? run + 1'b1 : CNT_W'(1);
      n_last = round_result;
    end
`endif
    fin_now = 1'b0;
    pw_now  = 2'b00;
    if (n_p1 == CNT_W'(WIN_TARGET)) begin
      fin_now = 1'b1; pw_now = 2'b10;
    end else if (n_p2 == CNT_W'(WIN_TARGET)) begin
      fin_now = 1'b1; pw_now = 2'b11;
    end
`ifdef SCOREBOARD_STREAK_EN
    else if (n_run == CNT_W'(STREAK_LEN)) begin
      fin_now = 1'b1; pw_now = (n_last == 2'b10) ? 2'b11 : 2'b10;
    end
`endif
    else if (n_rounds == CNT_W'(MAX_ROUNDS)) begin
      fin_now = 1'b1;
      pw_now  = (n_p1 > n_p2) ? 2'b10 : (n_p2 > n_p1) ? 2'b11 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rounds       <= '0;
      p1_wins      <= '0;
      p2_wins      <= '0;
      busy         <= 1'b0;
      fin          <= 1'b0;
      printwinner  <= 2'b00;
      done_pulse   <= 1'b0;
      illegal_seen <= 1'b0;
`ifdef SCOREBOARD_STREAK_EN
      last_win     <= 2'b00;
      run          <= '0;
`endif
    end else begin
      done_pulse <= 1'b0;
      if (start) begin
        state        <= PLAY;
        rounds       <= '0;
        p1_wins      <= '0;
        p2_wins      <= '0;
        busy         <= 1'b1;
        fin          <= 1'b0;
        printwinner  <= 2'b00;
        illegal_seen <= 1'b0;
`ifdef SCOREBOARD_STREAK_EN
        last_win     <= 2'b00;
        run          <= '0;
`endif
      end else if (acc) begin
        if (!scored) begin
          illegal_seen <= 1'b1;
        end else begin
          rounds  <= n_rounds;
          p1_wins <= n_p1;
          p2_wins <= n_p2;
`ifdef SCOREBOARD_STREAK_EN
          last_win <= n_last;
          run      <= n_run;
`endif
          if (fin_now) begin
            state       <= DONE;
            busy        <= 1'b0;
            fin         <= 1'b1;
            printwinner <= pw_now;
            done_pulse  <= 1'b1;
          end
        end
      end
    end
  end

endmodule
